// File: rtl/snes_map_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snes_map_pkg
//  Description : Shared descriptor layout, field indices and commit FSM states
//                for the programmable SNES region mapper.
//  Revision    : 1.0 - initial release
// ============================================================================
package snes_map_pkg;

    localparam logic [1:0] F_MATCH = 2'd0;
    localparam logic [1:0] F_BASE  = 2'd1;
    localparam logic [1:0] F_MASK  = 2'd2;
    localparam logic [1:0] F_FLAGS = 2'd3;

    localparam int FLAG_EN    = 0;
    localparam int FLAG_WR    = 1;
    localparam int FLAG_SAV   = 2;
    localparam int FLAG_LOROM = 3;

    typedef struct packed {
        logic [7:0]  bank_lo;
        logic [7:0]  bank_hi;
        logic [3:0]  page_lo;
        logic [3:0]  page_hi;
        logic [23:0] base;
        logic [23:0] mask;
        logic        lorom;
        logic        saveram;
        logic        writable;
        logic        enable;
    } snes_desc_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_COPY = 2'd2
    } commit_state_t;

endpackage
`default_nettype wire

// File: rtl/snes_region_match.sv
`default_nettype none
// ============================================================================
//  Module      : snes_region_match
//  Description : One window comparator: bank/page bounds check plus the
//                LoROM/HiROM offset extraction for a single descriptor.
//  Revision    : 1.0 - initial release
// ============================================================================
module snes_region_match
    import snes_map_pkg::*;
(
    input  logic [23:0] i_addr,
    input  logic [7:0]  i_bank_lo,
    input  logic [7:0]  i_bank_hi,
    input  logic [3:0]  i_page_lo,
    input  logic [3:0]  i_page_hi,
    input  logic        i_enable,
    input  logic        i_lorom,
    output logic        o_match,
    output logic [23:0] o_offset
);

    logic [7:0] w_bank;
    logic [3:0] w_page;

    assign w_bank = i_addr[23:16];
    assign w_page = i_addr[15:12];

    // Reversed bounds fall out naturally: no value satisfies lo <= x <= hi.
    assign o_match = i_enable
                   & (w_bank >= i_bank_lo) & (w_bank <= i_bank_hi)
                   & (w_page >= i_page_lo) & (w_page <= i_page_hi);

    assign o_offset = i_lorom ? {2'b00, i_addr[22:16], i_addr[14:0]}
                              : {1'b0, i_addr[22:0]};

endmodule
`default_nettype wire

// File: rtl/snes_region_mapper.sv
`default_nettype none
// ============================================================================
//  Module      : snes_region_mapper
//  Description : Programmable SNES address translator with double-buffered
//                window descriptors and a 2-stage lookup pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module snes_region_mapper
    import snes_map_pkg::*;
#(
    parameter  int NUM_REGIONS = 8,
    parameter  int MISS_CNT_W  = 16,
    localparam int IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1,
    localparam int CFG_AW      = IDX_W + 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [23:0]           SNES_ADDR,
    input  logic                  snes_addr_strobe,
    input  logic                  snes_idle,
    input  logic                  cfg_we,
    input  logic [CFG_AW-1:0]     cfg_addr,
    input  logic [31:0]           cfg_data,
    input  logic                  cfg_commit,
    input  logic                  cfg_clr_stats,
    output logic                  cfg_ready,
    output logic                  commit_done,
    output logic [23:0]           ROM_ADDR,
    output logic                  ROM_HIT,
    output logic                  IS_SAVERAM,
    output logic                  IS_WRITABLE,
    output logic                  map_valid,
    output logic [IDX_W-1:0]      region_idx,
    output logic [MISS_CNT_W-1:0] miss_count
);

    localparam logic [IDX_W:0] c_num_regions = NUM_REGIONS[IDX_W:0];

    snes_desc_t    shadow_q [NUM_REGIONS];
    snes_desc_t    shadow_d [NUM_REGIONS];
    snes_desc_t    active_q [NUM_REGIONS];
    snes_desc_t    active_d [NUM_REGIONS];
    commit_state_t state_q, state_d;

    logic                  s1_vld_q, s1_vld_d, s1_hit_q, s1_hit_d;
    logic                  s1_sav_q, s1_sav_d, s1_wr_q, s1_wr_d;
    logic [IDX_W-1:0]      s1_idx_q, s1_idx_d;
    logic [23:0]           s1_base_q, s1_base_d, s1_moff_q, s1_moff_d;
    logic [23:0]           rom_addr_q, rom_addr_d;
    logic                  rom_hit_q, rom_hit_d, is_sav_q, is_sav_d;
    logic                  is_wr_q, is_wr_d, map_valid_q, map_valid_d;
    logic [IDX_W-1:0]      region_idx_q, region_idx_d;
    logic [MISS_CNT_W-1:0] miss_q, miss_d;

    logic [NUM_REGIONS-1:0] w_match;
    logic [23:0]            w_offset [NUM_REGIONS];
    logic                   w_hit, w_miss;
    logic [IDX_W-1:0]       w_idx, w_cfg_idx;
    logic [1:0]             w_fld;
    snes_desc_t             w_sel;
    logic [23:0]            w_off;

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        snes_region_match u_match (
            .i_addr    (SNES_ADDR),
            .i_bank_lo (active_q[g].bank_lo),
            .i_bank_hi (active_q[g].bank_hi),
            .i_page_lo (active_q[g].page_lo),
            .i_page_hi (active_q[g].page_hi),
            .i_enable  (active_q[g].enable),
            .i_lorom   (active_q[g].lorom),
            .o_match   (w_match[g]),
            .o_offset  (w_offset[g])
        );
    end

    // Walk from the top so the lowest matching index ends up selected.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        w_sel = '0;
        w_off = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit = 1'b1;
                w_idx = IDX_W'(i);
                w_sel = active_q[i];
                w_off = w_offset[i];
            end
        end
    end

    assign cfg_ready   = (state_q == ST_IDLE);
    assign commit_done = (state_q == ST_COPY);
    assign w_cfg_idx   = cfg_addr[CFG_AW-1:2];
    assign w_fld       = cfg_addr[1:0];
    assign w_miss      = s1_vld_q & ~s1_hit_q;

    always_comb begin
        shadow_d = shadow_q;
        if (cfg_we && cfg_ready && ({1'b0, w_cfg_idx} < c_num_regions)) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (w_cfg_idx == IDX_W'(i)) begin
                    case (w_fld)
                        F_MATCH: begin
                            shadow_d[i].bank_lo = cfg_data[31:24];
                            shadow_d[i].bank_hi = cfg_data[23:16];
                            shadow_d[i].page_lo = cfg_data[15:12];
                            shadow_d[i].page_hi = cfg_data[11:8];
                        end
                        F_BASE:  shadow_d[i].base = cfg_data[23:0];
                        F_MASK:  shadow_d[i].mask = cfg_data[23:0];
                        default: begin
                            shadow_d[i].lorom    = cfg_data[FLAG_LOROM];
                            shadow_d[i].saveram  = cfg_data[FLAG_SAV];
                            shadow_d[i].writable = cfg_data[FLAG_WR];
                            shadow_d[i].enable   = cfg_data[FLAG_EN];
                        end
                    endcase
                end
            end
        end
    end

    // Commit waits for the bus to be idle and the pipeline to drain.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        case (state_q)
            ST_IDLE: if (cfg_commit) state_d = ST_PEND;
            ST_PEND: if (snes_idle && !s1_vld_q && !map_valid_q) state_d = ST_COPY;
            ST_COPY: begin
                active_d = shadow_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage 1 snapshots the winner's descriptor so a commit cannot skew stage 2.
    always_comb begin
        s1_vld_d  = snes_addr_strobe;
        s1_hit_d  = s1_hit_q;
        s1_idx_d  = s1_idx_q;
        s1_base_d = s1_base_q;
        s1_moff_d = s1_moff_q;
        s1_sav_d  = s1_sav_q;
        s1_wr_d   = s1_wr_q;
        if (snes_addr_strobe) begin
            s1_hit_d  = w_hit;
            s1_idx_d  = w_idx;
            s1_base_d = w_sel.base;
            s1_moff_d = w_off & w_sel.mask;
            s1_sav_d  = w_sel.saveram;
            s1_wr_d   = w_sel.writable | w_sel.saveram;
        end
    end

    always_comb begin
        map_valid_d  = s1_vld_q;
        rom_addr_d   = rom_addr_q;
        rom_hit_d    = rom_hit_q;
        is_sav_d     = is_sav_q;
        is_wr_d      = is_wr_q;
        region_idx_d = region_idx_q;
        if (s1_vld_q) begin
            rom_addr_d   = s1_hit_q ? (s1_base_q + s1_moff_q) : 24'd0;
            rom_hit_d    = s1_hit_q;
            is_sav_d     = s1_hit_q & s1_sav_q;
            is_wr_d      = s1_hit_q & s1_wr_q;
            region_idx_d = s1_hit_q ? s1_idx_q : '0;
        end
        miss_d = miss_q;
        if (cfg_clr_stats) begin
            miss_d = w_miss ? MISS_CNT_W'(1) : '0;
        end else if (w_miss && (miss_q != '1)) begin
            miss_d = miss_q + MISS_CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            state_q      <= ST_IDLE;
            s1_vld_q     <= 1'b0;
            s1_hit_q     <= 1'b0;
            s1_idx_q     <= '0;
            s1_base_q    <= '0;
            s1_moff_q    <= '0;
            s1_sav_q     <= 1'b0;
            s1_wr_q      <= 1'b0;
            map_valid_q  <= 1'b0;
            rom_addr_q   <= '0;
            rom_hit_q    <= 1'b0;
            is_sav_q     <= 1'b0;
            is_wr_q      <= 1'b0;
            region_idx_q <= '0;
            miss_q       <= '0;
        end else begin
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            state_q      <= state_d;
            s1_vld_q     <= s1_vld_d;
            s1_hit_q     <= s1_hit_d;
            s1_idx_q     <= s1_idx_d;
            s1_base_q    <= s1_base_d;
            s1_moff_q    <= s1_moff_d;
            s1_sav_q     <= s1_sav_d;
            s1_wr_q      <= s1_wr_d;
            map_valid_q  <= map_valid_d;
            rom_addr_q   <= rom_addr_d;
            rom_hit_q    <= rom_hit_d;
            is_sav_q     <= is_sav_d;
            is_wr_q      <= is_wr_d;
            region_idx_q <= region_idx_d;
            miss_q       <= miss_d;
        end
    end

    assign ROM_ADDR    = rom_addr_q;
    assign ROM_HIT     = rom_hit_q;
    assign IS_SAVERAM  = is_sav_q;
    assign IS_WRITABLE = is_wr_q;
    assign map_valid   = map_valid_q;
    assign region_idx  = region_idx_q;
    assign miss_count  = miss_q;

endmodule
`default_nettype wire

// File: doc/snes_region_mapper.md
Name: snes_region_mapper

Overview:
- Programmable successor to the fixed-mapper address decoder: NUM_REGIONS MCU-loaded window descriptors replace hard-coded per-mapper equations.
- Translates each SNES bus address to a PSRAM/SRAM address plus hit, saveram and writable qualifiers through a 2-stage pipeline.
- Descriptor updates are double-buffered (shadow/active) and committed only at a SNES bus idle point, so a mapping never changes mid-access.
- Sits between the SNES bus front end and the memory arbiter; configured by the MCU register interface.

Parameters:
NUM_REGIONS, 8, number of descriptor windows (1..16); lower index wins on overlap
MISS_CNT_W, 16, width of saturating miss counter
(localparam) IDX_W = max(1, clog2(NUM_REGIONS)); CFG_AW = IDX_W+2

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
SNES_ADDR  in  24  SNES bus address
snes_addr_strobe  in  1  one-cycle pulse: SNES_ADDR stable, translate it
snes_idle  in  1  high while no SNES access in flight (commit sync point)
cfg_we  in  1  shadow descriptor write strobe
cfg_addr  in  CFG_AW  {region index, field[1:0]}
cfg_data  in  32  write data
cfg_commit  in  1  pulse: copy shadow set to active set at next idle
cfg_clr_stats  in  1  pulse: clear miss counter
cfg_ready  out  1  low while a commit is pending
commit_done  out  1  one-cycle pulse when active set updated
ROM_ADDR  out  24  translated address
ROM_HIT  out  1  address hit an enabled region
IS_SAVERAM  out  1  hit region flagged saveram
IS_WRITABLE  out  1  hit region flagged writable or saveram
map_valid  out  1  one-cycle pulse: outputs updated for latest strobe
region_idx  out  IDX_W  index of winning region (0 on miss)
miss_count  out  MISS_CNT_W  strobes that hit no region, saturating

Behaviour:
- Reset: all shadow and active descriptors zero (all disabled); all outputs 0; cfg_ready=1; FSM IDLE.
- Descriptor fields: F0 = {bank_lo[31:24], bank_hi[23:16], page_lo[15:12], page_hi[11:8]}, bits [7:0] ignored; F1[23:0] = target base; F2[23:0] = offset mask; F3 = {.., lorom[3], saveram[2], writable[1], enable[0]}.
- Match rule: enable & bank_lo <= SNES_ADDR[23:16] <= bank_hi & page_lo <= SNES_ADDR[15:12] <= page_hi. Inclusive bounds, unsigned. Reversed bounds (lo > hi) never match.
- Offset: lorom=1 -> {2'b00, A[22:16], A[14:0]}; lorom=0 -> {1'b0, A[22:0]}.
- ROM_ADDR = (base + (offset & mask)) mod 2^24; carry out discarded.
- Pipeline stage 1, cycle after strobe: compare all regions against the active set, priority-encode the lowest matching index, register the index and hit.
- Pipeline stage 2, next cycle: add base to the masked offset and register all outputs. map_valid pulses here, 2 cycles after the strobe.
- Miss: ROM_HIT/IS_SAVERAM/IS_WRITABLE=0, ROM_ADDR=0, region_idx=0; miss_count increments, saturating at all-ones.
- Back-to-back strobes are accepted every cycle, fully pipelined.
- Outputs hold their value between map_valid pulses.
- Shadow writes: cfg_we with cfg_ready=1 writes the shadow field. With cfg_ready=0 the write is dropped. Region index >= NUM_REGIONS is ignored.
- Commit FSM:
  - IDLE -> PEND on cfg_commit; cfg_ready drops the following cycle.
  - PEND -> COPY on the first cycle with snes_idle=1 and no strobe in stage 1 or stage 2.
  - COPY: the whole active set is loaded from shadow in one cycle; commit_done pulses; return to IDLE; cfg_ready=1.
- cfg_commit while in PEND or COPY is ignored (no queueing).
- cfg_commit with snes_idle already 1 and pipeline empty: commit_done 2 cycles after the pulse.
- A strobe arriving in the same cycle as COPY uses the old set. The first strobe after COPY uses the new set.
- cfg_clr_stats clears miss_count; if a miss lands in the same cycle, the result is 1.
- RST asserted mid-commit or mid-pipeline returns everything to reset state immediately. A pending commit is lost.

Decomposition:
- Package snes_map_pkg: field index constants (F_MATCH, F_BASE, F_MASK, F_FLAGS), flag bit positions, descriptor struct typedef, FSM state enum.
- Sub-module snes_region_match: one descriptor vs address comparator producing match and offset. Instantiate NUM_REGIONS times in a generate loop.
- Priority encoder, adder stage and commit FSM live in the top module.

Test Plan:
- Region0 = banks 00-3F, pages 8-F, lorom, base 0x000000, mask 0x0FFFFF, enabled; commit; strobe 0x018000 -> 2 cycles later ROM_HIT=1, ROM_ADDR=0x008000, region_idx=0.
- Region0 as above plus region1 = banks 00-FF, pages 0-F, base 0xE00000, mask 0x001FFF, saveram; strobe 0x208000 -> region_idx=0. Strobe 0x706123 -> IS_SAVERAM=1, IS_WRITABLE=1, ROM_ADDR=0xE00123.
- Wrap: base 0xFFFF00, offset masked to 0x000200 -> ROM_ADDR=0x000100.
- Hold snes_idle=0, pulse cfg_commit, then cfg_we -> cfg_ready=0, write dropped, no commit_done. Raise snes_idle -> commit_done pulses; next strobe uses the new set.
- No regions enabled, 70000 strobes -> every output 0, miss_count saturates at 0xFFFF. Pulse cfg_clr_stats -> miss_count=0.
- Assert RST during PEND with strobes in flight -> all outputs 0, cfg_ready=1, active set disabled; a later commit_done requires a new cfg_commit.
